// File: rtl/cpu_pkg.sv
// Shared core-wide constants: bus widths, bubble encoding, opcodes and the fetch state enum.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RESET_PC  = '0;

    localparam logic [5:0] OP_ADD = 6'b000001;
    localparam logic [5:0] OP_SUB = 6'b000010;
    localparam logic [5:0] OP_AND = 6'b000011;
    localparam logic [5:0] OP_OR  = 6'b000100;
    localparam logic [5:0] OP_XOR = 6'b000101;
    localparam logic [5:0] OP_SLT = 6'b000110;
    localparam logic [5:0] OP_LW  = 6'b000111;
    localparam logic [5:0] OP_SW  = 6'b001000;
    localparam logic [5:0] OP_BEQ = 6'b001001;
    localparam logic [5:0] OP_BNE = 6'b001010;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/execute controls, instruction-memory port and the IF/ID outputs.
interface if_stage_if
    import cpu_pkg::*;
();
    logic              stall;
    logic              flush;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] ifid_instr;
    logic [ADDR_W-1:0] ifid_pcplus4;
    logic              ifid_valid;

    modport master (
        input  stall, flush, redirect, redirect_target, instr,
        output address, ifid_instr, ifid_pcplus4, ifid_valid
    );

    modport slave (
        output stall, flush, redirect, redirect_target, instr,
        input  address, ifid_instr, ifid_pcplus4, ifid_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, combinational imem address, IF/ID capture; 1-cycle fetch latency.
// Stall freezes PC and IF/ID; redirect costs one bubble and overrides stall/flush.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RST_PC   = RESET_PC,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    if_stage_if.master      bus
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_plus4, target_aligned;
    logic              ifid_load, ifid_clr;

    assign pc_plus4       = pc + ADDR_W'(4);
    assign target_aligned = bus.redirect_target & ~ADDR_W'(3);
    assign bus.address    = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ifid_load = 1'b0;
        ifid_clr  = 1'b0;
        unique case (state)
            BOOT: begin
                // Inputs are ignored for one cycle so the first fetch is always RST_PC.
                state_nxt = RUN;
                ifid_clr  = 1'b1;
            end
            RUN: begin
                if (bus.redirect) begin
                    pc_nxt   = target_aligned;
                    ifid_clr = 1'b1;
                end else if (bus.stall) begin
                    ifid_clr = bus.flush;
                end else if (bus.flush) begin
                    pc_nxt   = pc_plus4;
                    ifid_clr = 1'b1;
                end else begin
                    pc_nxt    = pc_plus4;
                    ifid_load = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RST_PC;
        else        pc <= pc_nxt;
    end

    // Holding is the implicit else: neither load nor clear leaves IF/ID untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ifid_instr   <= NOP_WORD;
            bus.ifid_pcplus4 <= '0;
            bus.ifid_valid   <= 1'b0;
        end else if (ifid_clr) begin
            bus.ifid_instr   <= NOP_WORD;
            bus.ifid_pcplus4 <= '0;
            bus.ifid_valid   <= 1'b0;
        end else if (ifid_load) begin
            bus.ifid_instr   <= bus.instr;
            bus.ifid_pcplus4 <= pc_plus4;
            bus.ifid_valid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, sequential fetch with wrap, redirect, stall, flush, async reset.
module tb_if_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [DATA_W-1:0] im [0:255];

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr = im[bus.address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [ADDR_W-1:0] t);
        bus.stall           = s;
        bus.flush           = f;
        bus.redirect        = r;
        bus.redirect_target = t;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [7:0] pc4,
                            input logic v, input logic [7:0] addr);
        chk({tag, ".instr"}, bus.ifid_instr, ins);
        chk({tag, ".pc4"},   32'(bus.ifid_pcplus4), 32'(pc4));
        chk({tag, ".valid"}, 32'(bus.ifid_valid), 32'(v));
        chk({tag, ".addr"},  32'(bus.address), 32'(addr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) im[i] = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) im[i*4] = 32'hC0DE_0000 | 32'(i*4);
        im[0] = 32'h0000_0000;
        im[4] = 32'h1421_0003;
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        #2 rst_n = 1'b0;
        #1 chk_ifid("reset", 32'h0, 8'd0, 1'b0, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // BOOT cycle, then sequential fetch from 0.
        step(); chk_ifid("boot", 32'h0, 8'd0, 1'b0, 8'd0);
        step(); chk_ifid("f0", 32'h0000_0000, 8'd4, 1'b1, 8'd4);
        step(); chk_ifid("f4", 32'h1421_0003, 8'd8, 1'b1, 8'd8);
        step(); chk_ifid("f8", 32'hC0DE_0008, 8'd12, 1'b1, 8'd12);

        // Redirect at PC=12 to 44: one bubble, then target.
        drive(1'b0, 1'b0, 1'b1, 8'd44);
        step(); chk_ifid("redir", 32'h0, 8'd0, 1'b0, 8'd44);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("tgt44", 32'hC0DE_002C, 8'd48, 1'b1, 8'd48);

        // Stall three cycles at PC=48.
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(); chk_ifid($sformatf("stall%0d", i), 32'hC0DE_002C, 8'd48, 1'b1, 8'd48);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("rel48", 32'hC0DE_0030, 8'd52, 1'b1, 8'd52);
        step(); chk_ifid("f52", 32'hC0DE_0034, 8'd56, 1'b1, 8'd56);

        // Stall+flush at 56 holds PC, flush alone advances.
        drive(1'b1, 1'b1, 1'b0, 8'd0);
        step(); chk_ifid("stflush", 32'h0, 8'd0, 1'b0, 8'd56);
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        step(); chk_ifid("flush", 32'h0, 8'd0, 1'b0, 8'd60);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("f60", 32'hC0DE_003C, 8'd64, 1'b1, 8'd64);

        // All three together, misaligned target 45 -> 44.
        drive(1'b1, 1'b1, 1'b1, 8'd45);
        step(); chk_ifid("all3", 32'h0, 8'd0, 1'b0, 8'd44);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("tgt45", 32'hC0DE_002C, 8'd48, 1'b1, 8'd48);

        // Wrap-around from 248.
        drive(1'b0, 1'b0, 1'b1, 8'd248);
        step(); chk_ifid("to248", 32'h0, 8'd0, 1'b0, 8'd248);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("w248", 32'hC0DE_00F8, 8'd252, 1'b1, 8'd252);
        step(); chk_ifid("w252", 32'hC0DE_00FC, 8'd0, 1'b1, 8'd0);
        step(); chk_ifid("w0", 32'h0000_0000, 8'd4, 1'b1, 8'd4);

        // Reach PC=76, then async reset between edges with stall+redirect asserted.
        drive(1'b0, 1'b0, 1'b1, 8'd72);
        step(); chk_ifid("to72", 32'h0, 8'd0, 1'b0, 8'd72);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("f72", 32'hC0DE_0048, 8'd76, 1'b1, 8'd76);
        drive(1'b1, 1'b0, 1'b1, 8'd100);
        #3 rst_n = 1'b0;
        #1 chk_ifid("arst", 32'h0, 8'd0, 1'b0, 8'd0);
        #2 rst_n = 1'b1;
        // Redirect left asserted through BOOT must be ignored.
        drive(1'b0, 1'b0, 1'b1, 8'd100);
        step(); chk_ifid("reboot", 32'h0, 8'd0, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        step(); chk_ifid("rf0", 32'h0000_0000, 8'd4, 1'b1, 8'd4);
        step(); chk_ifid("rf4", 32'h1421_0003, 8'd8, 1'b1, 8'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RISC core. Owns the program counter, drives the combinational instruction memory's byte address, and captures the returned word into the IF/ID pipeline register. Applies stall, flush and branch/jump redirect requests from the hazard and execute logic. Feeds the decode stage.

## Interface
- ADDR_W, 8, PC / instruction-memory byte-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value after reset
- NOP_INSTR, 32'h0000_0000, word loaded into IF/ID for a bubble
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low (one clock; reset asynchronous active-low)
- Stall  in  1  hold PC and IF/ID contents
- Flush  in  1  replace IF/ID contents with a bubble
- Redirect  in  1  taken branch/jump resolved downstream
- RedirectTarget  in  ADDR_W  new PC for Redirect
- Address  out  ADDR_W  byte address to instruction memory; equals PC
- Instr  in  DATA_W  word returned combinationally by instruction memory
- IfId_Instr  out  DATA_W  registered instruction to decode
- IfId_PcPlus4  out  ADDR_W  registered PC+4 of that instruction
- IfId_Valid  out  1  IF/ID holds a real instruction

## Operation
- FSM with two states: BOOT and RUN. Rst_n low forces BOOT.
- BOOT lasts exactly one cycle after reset release. PC is held at RESET_PC and IF/ID stays a bubble. The next state is RUN unconditionally. All inputs are ignored in BOOT.
- RUN, priority is Redirect > Stall > normal:
  - Redirect=1: PC <= {RedirectTarget[ADDR_W-1:2], 2'b00}. IF/ID <= bubble. Stall and Flush are ignored this cycle.
  - Stall=1, Flush=0: PC and IF/ID both hold.
  - Stall=1, Flush=1: PC holds and IF/ID <= bubble.
  - Stall=0, Flush=1: PC <= PC+4 and IF/ID <= bubble.
  - Otherwise: IF/ID <= {Instr, PC+4, valid=1} and PC <= PC+4.
- A bubble is IfId_Instr=NOP_INSTR, IfId_PcPlus4=0, IfId_Valid=0.
- Arithmetic: PC+4 is modulo 2^ADDR_W, so 252+4 wraps to 0 with no flag. PC[1:0] is always 00.
- Address is driven combinationally from the PC register, never from next-PC.

## Timing
- Reset values, asynchronous: PC=RESET_PC, IfId_Instr=NOP_INSTR, IfId_PcPlus4=0, IfId_Valid=0, state=BOOT.
- Address reflects the new PC in the same cycle the PC register updates.
- Fetch latency is one cycle. A word addressed in cycle N appears on IfId_* after edge N+1.
- Redirect penalty is one bubble:
  - Redirect sampled at edge N puts the target on Address after N.
  - The target instruction appears on IF/ID after edge N+1.
- Stall may be held any number of cycles. Outputs stay frozen, with no dropped or duplicated instruction on release.
- Rst_n asserted mid-operation clears state immediately, regardless of Stall or Redirect. The first post-reset fetch is RESET_PC.

## Structure
- Shared package `cpu_pkg`:
  - ADDR_W, DATA_W, NOP_INSTR
  - opcode constants (ADD=000001 … BNE=001010)
  - fetch state enum {BOOT, RUN}
- Single module. The PC register and the IF/ID register are two always blocks in the same file.
- Optional sub-module `ifid_reg` holds the pipeline register with hold/clear controls, reusable for ID/EX.

## Test plan
- Reset/boot: release Rst_n with IM[0]=0, IM[4]=32'h1421_0003.
  - Cycle 1 after release: Address=0, IfId_Valid=0.
  - Next edge: IF/ID={0,4,1}, then {32'h1421_0003,8,1}.
- Sequential fetch across wrap: run from PC=248. Address reads 248, 252, 0, 4. IfId_PcPlus4 reads 252, 0, 4.
- Redirect: at PC=12 assert Redirect with target 44 (also try 45).
  - Next Address=44 and IF/ID is a bubble.
  - The following IF/ID holds IM[44] with PcPlus4=48.
  - Target 45 aligns to 44.
- Stall hold: assert Stall for 3 cycles at PC=48. Address stays 48 and IF/ID is unchanged. On release, IM[48] enters IF/ID exactly once.
- Simultaneous events:
  - Redirect+Stall+Flush together gives a redirect.
  - Stall+Flush at PC=56 gives PC held at 56 with IfId_Valid=0.
  - Flush alone at PC=56 gives PC=60 with a bubble.
- Async reset mid-run: drop Rst_n between edges at PC=76. Outputs clear immediately without a clock edge, and BOOT re-runs from 0.
